// File: rtl/sync_bit_edge_filter.sv
// Glitch filter, edge pulse and counter stage behind a single-bit synchronizer (clkB domain).
// Accepted edges are queued as {rise, seq} in a 2-entry registered FIFO with valid/ready.
module sync_bit_edge_filter #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned CNT_W       = 16,
  parameter bit          RESET_LEVEL = 1'b0
) (
  input  logic             clkB,
  input  logic             rstB_n,
  input  logic             sync_bitB,
  input  logic             clear,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] edge_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_rise,
  output logic [CNT_W-1:0] evt_seq,
  output logic             overflow
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);

  logic             level_q, level_d;
  logic [FW-1:0]    filt_cnt_q, filt_cnt_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic             head_rise_q, head_rise_d, tail_rise_q, tail_rise_d;
  logic [CNT_W-1:0] head_seq_q, head_seq_d, tail_seq_q, tail_seq_d;
  logic             ovf_q, ovf_d;

  logic             differs, accept, push, pop;
  logic [CNT_W-1:0] new_cnt;

  always_comb begin
    differs    = sync_bitB != level_q;
    accept     = differs && (filt_cnt_q == FiltMax);
    level_d    = level_q;
    filt_cnt_d = '0;
    if (differs) begin
      if (accept) level_d = sync_bitB;
      else        filt_cnt_d = filt_cnt_q + 1'b1;
    end
    rise_d = accept & sync_bitB;
    fall_d = accept & ~sync_bitB;
  end

  always_comb begin
    new_cnt     = edge_cnt_q + 1'b1;
    push        = accept & ~clear;
    pop         = head_vld_q & evt_ready;
    edge_cnt_d  = edge_cnt_q;
    head_vld_d  = head_vld_q;
    tail_vld_d  = tail_vld_q;
    head_rise_d = head_rise_q;
    head_seq_d  = head_seq_q;
    tail_rise_d = tail_rise_q;
    tail_seq_d  = tail_seq_q;
    ovf_d       = ovf_q;
    if (clear) begin
      edge_cnt_d = '0;
      head_vld_d = 1'b0;
      tail_vld_d = 1'b0;
      ovf_d      = 1'b0;
    end else begin
      if (accept) edge_cnt_d = new_cnt;
      if (!head_vld_q) begin
        if (push) begin
          head_vld_d  = 1'b1;
          head_rise_d = sync_bitB;
          head_seq_d  = new_cnt;
        end
      end else if (!tail_vld_q) begin
        if (push && (pop || 1'b0) ) begin
          head_rise_d = sync_bitB;
          head_seq_d  = new_cnt;
        end else if (pop) begin
          head_vld_d = 1'b0;
        end else if (push) begin
          tail_vld_d  = 1'b1;
          tail_rise_d = sync_bitB;
          tail_seq_d  = new_cnt;
        end
      end else begin
        // Full: a pop frees the tail slot for a same-cycle push; otherwise a push is dropped.
        if (pop) begin
          head_rise_d = tail_rise_q;
          head_seq_d  = tail_seq_q;
          if (push) begin
            tail_rise_d = sync_bitB;
            tail_seq_d  = new_cnt;
          end else begin
            tail_vld_d = 1'b0;
          end
        end else if (push) begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clkB or negedge rstB_n) begin
    if (!rstB_n) begin
      level_q     <= RESET_LEVEL;
      filt_cnt_q  <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      edge_cnt_q  <= '0;
      head_vld_q  <= 1'b0;
      tail_vld_q  <= 1'b0;
      head_rise_q <= 1'b0;
      head_seq_q  <= '0;
      tail_rise_q <= 1'b0;
      tail_seq_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      level_q     <= level_d;
      filt_cnt_q  <= filt_cnt_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      edge_cnt_q  <= edge_cnt_d;
      head_vld_q  <= head_vld_d;
      tail_vld_q  <= tail_vld_d;
      head_rise_q <= head_rise_d;
      head_seq_q  <= head_seq_d;
      tail_rise_q <= tail_rise_d;
      tail_seq_q  <= tail_seq_d;
      ovf_q       <= ovf_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign edge_count = edge_cnt_q;
  assign evt_valid  = head_vld_q;
  assign evt_rise   = head_rise_q;
  assign evt_seq    = head_seq_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_sync_bit_edge_filter.sv
// Directed bench: dut (FILTER_LEN=4, CNT_W=16) and dut2 (FILTER_LEN=1, CNT_W=2) share clock/reset.
module tb_sync_bit_edge_filter;

  logic        clkB = 1'b0;
  logic        rstB_n;
  logic        sb, clr, rdy;
  logic        lvl, rp, fp, ev, er, ovf;
  logic [15:0] cnt, seq;
  logic        sb2, clr2, rdy2;
  logic        lvl2, rp2, fp2, ev2, er2, ovf2;
  logic [1:0]  cnt2, seq2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clkB = ~clkB;

  sync_bit_edge_filter #(.FILTER_LEN(4), .CNT_W(16), .RESET_LEVEL(1'b0)) dut (
    .clkB(clkB), .rstB_n(rstB_n), .sync_bitB(sb), .clear(clr),
    .level_out(lvl), .rise_pulse(rp), .fall_pulse(fp), .edge_count(cnt),
    .evt_valid(ev), .evt_ready(rdy), .evt_rise(er), .evt_seq(seq), .overflow(ovf)
  );

  sync_bit_edge_filter #(.FILTER_LEN(1), .CNT_W(2), .RESET_LEVEL(1'b0)) dut2 (
    .clkB(clkB), .rstB_n(rstB_n), .sync_bitB(sb2), .clear(clr2),
    .level_out(lvl2), .rise_pulse(rp2), .fall_pulse(fp2), .edge_count(cnt2),
    .evt_valid(ev2), .evt_ready(rdy2), .evt_rise(er2), .evt_seq(seq2), .overflow(ovf2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clkB);
      #1;
    end
  endtask

  initial begin
    logic [1:0] seq_exp [5];
    seq_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rstB_n = 1'b0; sb = 1'b0; clr = 1'b0; rdy = 1'b0;
    sb2 = 1'b0; clr2 = 1'b0; rdy2 = 1'b1;
    steps(3);
    chk("rst_level", 32'(lvl), 32'd0);
    chk("rst_rise", 32'(rp), 32'd0);
    chk("rst_fall", 32'(fp), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_valid", 32'(ev), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rstB_n = 1'b1;

    // Rise needs four consecutive high samples
    sb = 1'b1; steps(3);
    chk("t1_level_early", 32'(lvl), 32'd0);
    chk("t1_rise_early", 32'(rp), 32'd0);
    steps(1);
    chk("t1_level", 32'(lvl), 32'd1);
    chk("t1_rise", 32'(rp), 32'd1);
    chk("t1_count", 32'(cnt), 32'd1);
    chk("t1_valid", 32'(ev), 32'd1);
    chk("t1_evt_rise", 32'(er), 32'd1);
    chk("t1_seq", 32'(seq), 32'd1);
    steps(1);
    chk("t1_rise_one_cycle", 32'(rp), 32'd0);

    // Three-sample glitch is rejected
    sb = 1'b0; steps(3);
    chk("t2_level_hold", 32'(lvl), 32'd1);
    sb = 1'b1; steps(1);
    chk("t2_no_fall", 32'(fp), 32'd0);
    chk("t2_count", 32'(cnt), 32'd1);

    // Fill the FIFO and overflow it
    sb = 1'b0; steps(4);
    chk("t3_fall", 32'(fp), 32'd1);
    chk("t3_level0", 32'(lvl), 32'd0);
    chk("t3_count2", 32'(cnt), 32'd2);
    sb = 1'b1; steps(4);
    chk("t3_count3", 32'(cnt), 32'd3);
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_head_seq", 32'(seq), 32'd1);
    chk("t3_head_rise", 32'(er), 32'd1);
    chk("t3_head_valid", 32'(ev), 32'd1);
    rdy = 1'b1; steps(1);
    chk("t3_pop1_seq", 32'(seq), 32'd2);
    chk("t3_pop1_rise", 32'(er), 32'd0);
    chk("t3_pop1_valid", 32'(ev), 32'd1);
    steps(1);
    chk("t3_empty", 32'(ev), 32'd0);
    rdy = 1'b0;

    clr = 1'b1; steps(1); clr = 1'b0;
    chk("clr_count", 32'(cnt), 32'd0);
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_valid", 32'(ev), 32'd0);
    chk("clr_level", 32'(lvl), 32'd1);

    // Full FIFO with pop and push in the same cycle
    sb = 1'b0; steps(4);
    sb = 1'b1; steps(4);
    chk("t4_full_head", 32'(seq), 32'd1);
    sb = 1'b0; steps(3);
    rdy = 1'b1; steps(1);
    chk("t4_no_ovf", 32'(ovf), 32'd0);
    chk("t4_head2", 32'(seq), 32'd2);
    chk("t4_head2_rise", 32'(er), 32'd1);
    chk("t4_count3", 32'(cnt), 32'd3);
    steps(1);
    rdy = 1'b0;
    chk("t4_head3", 32'(seq), 32'd3);
    chk("t4_head3_rise", 32'(er), 32'd0);
    chk("t4_head3_valid", 32'(ev), 32'd1);

    // Async reset mid-filter with FIFO occupied
    sb = 1'b1; steps(4);
    chk("t6_pre_level", 32'(lvl), 32'd1);
    chk("t6_pre_count", 32'(cnt), 32'd4);
    sb = 1'b0; steps(2);
    #2 rstB_n = 1'b0;
    #1;
    chk("t6_level", 32'(lvl), 32'd0);
    chk("t6_count", 32'(cnt), 32'd0);
    chk("t6_valid", 32'(ev), 32'd0);
    chk("t6_seq", 32'(seq), 32'd0);
    chk("t6_rise", 32'(er), 32'd0);
    chk("t6_ovf", 32'(ovf), 32'd0);
    steps(1);
    rstB_n = 1'b1;

    // Input differing from reset level after release is a normal filtered edge
    sb = 1'b1; steps(3);
    chk("pr_level_early", 32'(lvl), 32'd0);
    steps(1);
    chk("pr_level", 32'(lvl), 32'd1);
    chk("pr_rise", 32'(rp), 32'd1);
    chk("pr_seq", 32'(seq), 32'd1);

    // dut2: FILTER_LEN=1, 2-bit sequence wraps
    for (int i = 0; i < 5; i++) begin
      sb2 = (i % 2 == 0) ? 1'b1 : 1'b0;
      steps(1);
      chk("t5_seq", 32'(seq2), 32'(seq_exp[i]));
      chk("t5_evt_rise", 32'(er2), 32'(sb2));
      chk("t5_count", 32'(cnt2), 32'(seq_exp[i]));
      chk("t5_valid", 32'(ev2), 32'd1);
    end
    rdy2 = 1'b0; sb2 = 1'b0; steps(1);
    sb2 = 1'b1; steps(1);
    chk("t5_ovf", 32'(ovf2), 32'd1);
    chk("t5_count3", 32'(cnt2), 32'd3);
    chk("t5_head", 32'(seq2), 32'd1);
    clr2 = 1'b1; sb2 = 1'b0; steps(1);
    chk("t5_clr_level", 32'(lvl2), 32'd0);
    chk("t5_clr_fall", 32'(fp2), 32'd1);
    chk("t5_clr_count", 32'(cnt2), 32'd0);
    chk("t5_clr_valid", 32'(ev2), 32'd0);
    chk("t5_clr_ovf", 32'(ovf2), 32'd0);
    clr2 = 1'b0; steps(1);
    chk("t5_post_count", 32'(cnt2), 32'd0);
    chk("t5_post_valid", 32'(ev2), 32'd0);
    chk("t5_post_fall", 32'(fp2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
